// File: rtl/dbl_sha_feeder_if.sv
// rtl/dbl_sha_feeder_if.sv - message word stream between the feeder and the SHA core input
interface dbl_sha_feeder_if #(
  parameter int WORD_W = 32
) ();
  logic              dbl_vld;
  logic [WORD_W-1:0] dbl_din;
  logic              dbl_last;
  logic              dbl_rdy;

  modport master (output dbl_vld, output dbl_din, output dbl_last, input dbl_rdy);
  modport slave  (input dbl_vld, input dbl_din, input dbl_last, output dbl_rdy);
endinterface

// File: rtl/dbl_sha_feeder.sv
// rtl/dbl_sha_feeder.sv - second-pass feeder: captured digest streamed as a padded SHA block
module dbl_sha_feeder #(
  parameter int WORD_W = 32,
  parameter int HASH_W = 256,
  parameter int BLK_W  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [HASH_W-1:0] hash,
  input  logic              reg_dbl,
  input  logic              mode_raw,
  input  logic              err_clr,
  dbl_sha_feeder_if.master  bus,
  output logic              dbl_busy,
  output logic              dbl_fin,
  output logic              err_ovr,
  output logic              err_nohash
);
  localparam int HW = HASH_W / WORD_W;
  localparam int NW = BLK_W / WORD_W;
  localparam int CW = $clog2(NW);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [CW:0] LAST_FULL = (CW+1)'(NW - 1);
  localparam logic [CW:0] LAST_RAW  = (CW+1)'(HW - 1);

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic [HASH_W-1:0] hash_r;
  logic              hv;
  logic              raw_r;
  logic              vld_r;
  logic [WORD_W-1:0] din_r;
  logic              last_r;
  logic              fin_r;
  logic              ovr_r;
  logic              nohash_r;

  logic [CW:0]       nxt;
  logic [CW:0]       last_idx;
  logic              hs;
  logic [HASH_W-1:0] start_src;

  // Block word at a given index: digest words MSB first, then the 1-bit pad, zeros, bit length.
  function automatic logic [WORD_W-1:0] word_of(input logic [CW:0] idx,
                                                input logic [HASH_W-1:0] h);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < HW; i++) begin
      if (idx == (CW+1)'(i)) w = h[HASH_W-1-i*WORD_W -: WORD_W];
    end
    if (idx == (CW+1)'(HW)) w = {1'b1, {(WORD_W-1){1'b0}}};
    else if (idx == LAST_FULL) w = WORD_W'(HASH_W);
    return w;
  endfunction

  // Next index, final index for the latched mode, handshake, and digest used at start.
  always_comb begin
    nxt       = (CW+1)'(cnt) + (CW+1)'(1);
    last_idx  = raw_r ? LAST_RAW : LAST_FULL;
    hs        = vld_r && bus.dbl_rdy;
    start_src = done ? hash : hash_r;
  end

  // Controller and registered output word: the next word is prepared on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hash_r <= '0;
      hv     <= 1'b0;
      raw_r  <= 1'b0;
      vld_r  <= 1'b0;
      din_r  <= '0;
      last_r <= 1'b0;
      fin_r  <= 1'b0;
    end else begin
      fin_r <= 1'b0;
      case (state)
        IDLE: begin
          if (done) begin
            hash_r <= hash;
            hv     <= 1'b1;
          end
          if (reg_dbl && (hv || done)) begin
            state  <= SEND;
            cnt    <= '0;
            raw_r  <= mode_raw;
            vld_r  <= 1'b1;
            din_r  <= word_of('0, start_src);
            last_r <= mode_raw && (HW == 1);
          end
        end
        default: begin
          if (hs) begin
            if (last_r) begin
              state  <= IDLE;
              hv     <= 1'b0;
              vld_r  <= 1'b0;
              din_r  <= '0;
              last_r <= 1'b0;
              fin_r  <= 1'b1;
            end else begin
              cnt    <= nxt[CW-1:0];
              din_r  <= word_of(nxt, hash_r);
              last_r <= (nxt == last_idx);
            end
          end
        end
      endcase
    end
  end

  // Sticky error flags; a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_r    <= 1'b0;
      nohash_r <= 1'b0;
    end else begin
      if (err_clr) begin
        ovr_r    <= 1'b0;
        nohash_r <= 1'b0;
      end
      if (state == SEND && done) ovr_r <= 1'b1;
      if (state == IDLE && reg_dbl && !hv && !done) nohash_r <= 1'b1;
    end
  end

  assign bus.dbl_vld  = vld_r;
  assign bus.dbl_din  = din_r;
  assign bus.dbl_last = last_r;
  assign dbl_busy     = (state == SEND);
  assign dbl_fin      = fin_r;
  assign err_ovr      = ovr_r;
  assign err_nohash   = nohash_r;
endmodule
